ula_writeback: RTL and testbench
================================

# ula_writeback

Result/flag retirement stage directly downstream of the ALU. It accepts each ALU result together with its four status flags (Z, C, S, O) and a per-operation flag-update mask. It holds results in a 2-entry FIFO until the register file accepts them, and keeps the architectural flag register. It also evaluates branch conditions against the current flags for the control unit.

## Interface
Parameters:
- bits_palavra, 16, datapath word width (matches the ALU result width)
- bits_endereco, 4, register-file destination address width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valido  in  1  ALU result valid
- in_pronto  out  1  stage can accept (FIFO not full)
- resultado_in  in  bits_palavra  ALU result
- end_dest_in  in  bits_endereco  destination register address
- escreve_in  in  1  result is to be written to the register file
- flags_in  in  4  ALU flags {Z,C,S,O}, bit 3 = Z … bit 0 = O
- mascara_flags  in  4  per-flag update enable, same bit order
- wb_valido  out  1  head entry available to register file
- wb_pronto  in  1  register file accepts head entry
- wb_dado  out  bits_palavra  head result
- wb_end  out  bits_endereco  head destination address
- wb_escreve  out  1  head write enable qualifier
- limpa_flags  in  1  synchronous flag-register clear
- flags  out  4  architectural flag register {Z,C,S,O}
- cond_sel  in  3  condition code to evaluate
- cond_ok  out  1  condition result (combinational from flags)

## Operation
- Push = in_valido & in_pronto. Pop = wb_valido & wb_pronto.
- FIFO: 2 entries {resultado, end_dest, escreve}, with read pointer, write pointer and 2-bit count. Pointers wrap modulo 2.
- in_pronto = (count != 2), combinational from count. wb_valido = (count != 0).
- wb_dado, wb_end and wb_escreve present the head entry, taken from registered storage. When empty they hold their last value; after reset they are 0.
- Push and pop in the same cycle: count is unchanged, both pointers advance. At count 2 no push can occur. At count 0 no pop can occur.
- Flags update on push, not on pop, so they follow ALU issue order:
  - For each bit i: flags[i] <= mascara_flags[i] ? flags_in[i] : flags[i].
- limpa_flags clears unmasked bits to 0. If it coincides with a push, the masked bits take flags_in. An update therefore wins over clear, bit by bit.
- Entries with escreve_in = 0 are still queued and popped, with wb_escreve = 0. This keeps ordering intact.
- cond_sel encoding:
  - 000 always 1
  - 001 Z
  - 010 !Z
  - 011 S
  - 100 !S
  - 101 C
  - 110 O
  - 111 S^O (signed less-than)
- cond_ok reflects the registered flags, never flags_in in flight.

## Timing
- Reset (rst_n = 0, asynchronous):
  - count = 0, pointers = 0
  - flags = 4'b0000
  - wb_valido = 0, in_pronto = 1
  - wb_dado, wb_end, wb_escreve = 0
  - cond_ok = (cond_sel == 000 or 010 or 100)
- Reset asserted mid-operation drops all queued entries immediately. Flags go to 0.
- Latency: a push at edge N makes wb_valido = 1 with that entry's data after edge N; this is 1 cycle.
- Back-to-back pushes are accepted every cycle while wb_pronto = 1 (sustained throughput 1/cycle).
- With wb_pronto = 0, two pushes fill the FIFO and in_pronto drops after the second edge. in_pronto returns to 1 the cycle after the first pop.
- Flag update is visible on flags and cond_ok the cycle after the push edge. In the push cycle itself, cond_ok uses the old flags.
- wb outputs are stable while wb_valido = 1 and wb_pronto = 0.

## Test plan
- Reset then single push (resultado 16'h1234, end 3, escreve 1, flags 4'b0100, mask 4'b1111), wb_pronto = 1:
  - wb_valido high 1 cycle later with wb_dado 1234, wb_end 3.
  - flags = 0100, cond_ok for sel 101 = 1.
- Stall fill with wb_pronto = 0, pushes A = 0001 then B = 0002, third push C attempted:
  - in_pronto = 0 after B, C is not accepted.
  - Raising wb_pronto pops A then B in order, and C is then accepted.
- Simultaneous push/pop at count 1 over 8 consecutive cycles with values 1..8:
  - Count stays at 1 throughout.
  - Outputs emerge 1..8 in order with no loss across pointer wrap.
- Masked update: flags = 1111, push with mask 4'b0101 and flags_in 0000:
  - flags = 1010.
  - Then limpa_flags with push mask 0001 and flags_in 0001 gives flags = 0001.
- Condition sweep: for each flags value 0000..1111, step cond_sel 000..111:
  - cond_ok matches the encoding, e.g. S = 1, O = 0 gives sel 111 = 1.
  - S = 1, O = 1 gives sel 111 = 0.
- Reset mid-operation: with the FIFO full and flags 1111, assert rst_n low asynchronously between edges:
  - wb_valido = 0, in_pronto = 1, flags = 0000 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ula_writeback_if.sv
// Handshake bundle between the ALU, the writeback stage and the register file.
interface ula_writeback_if #(
  parameter int unsigned bits_palavra  = 16,
  parameter int unsigned bits_endereco = 4
);
  logic                     in_valido;
  logic                     in_pronto;
  logic [bits_palavra-1:0]  resultado_in;
  logic [bits_endereco-1:0] end_dest_in;
  logic                     escreve_in;
  logic [3:0]               flags_in;
  logic [3:0]               mascara_flags;

  logic                     wb_valido;
  logic                     wb_pronto;
  logic [bits_palavra-1:0]  wb_dado;
  logic [bits_endereco-1:0] wb_end;
  logic                     wb_escreve;

  // Environment side: ALU producer plus register-file acceptance.
  modport master (
    output in_valido, resultado_in, end_dest_in, escreve_in, flags_in, mascara_flags,
    output wb_pronto,
    input  in_pronto, wb_valido, wb_dado, wb_end, wb_escreve
  );

  // Writeback stage side.
  modport slave (
    input  in_valido, resultado_in, end_dest_in, escreve_in, flags_in, mascara_flags,
    input  wb_pronto,
    output in_pronto, wb_valido, wb_dado, wb_end, wb_escreve
  );
endinterface

// File: rtl/ula_writeback.sv
// ALU result/flag retirement: 2-entry result FIFO toward the register file,
// architectural flag register updated in issue order, branch condition evaluation.
module ula_writeback #(
  parameter int unsigned bits_palavra  = 16,
  parameter int unsigned bits_endereco = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ula_writeback_if.slave       bus,
  input  logic                 limpa_flags,
  output logic [3:0]           flags,
  input  logic [2:0]           cond_sel,
  output logic                 cond_ok
);

  localparam int unsigned PROF = 2;

  typedef struct packed {
    logic [bits_palavra-1:0]  resultado;
    logic [bits_endereco-1:0] end_dest;
    logic                     escreve;
  } entrada_t;

  entrada_t   mem_q [PROF];
  entrada_t   mem_d [PROF];
  entrada_t   head_q, head_d;
  entrada_t   entrada_in;
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic [3:0] flags_q, flags_d;
  logic       push, pop;

  assign entrada_in    = '{resultado: bus.resultado_in, end_dest: bus.end_dest_in,
                           escreve: bus.escreve_in};
  assign bus.in_pronto = (count_q != 2'd2);
  assign bus.wb_valido = (count_q != 2'd0);
  assign push          = bus.in_valido & bus.in_pronto;
  assign pop           = bus.wb_valido & bus.wb_pronto;

  assign bus.wb_dado    = head_q.resultado;
  assign bus.wb_end     = head_q.end_dest;
  assign bus.wb_escreve = head_q.escreve;
  assign flags          = flags_q;

  // FIFO bookkeeping; head register tracks the next head and holds when empty.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (push) begin
      mem_d[wr_ptr_q] = entrada_in;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (count_d != 2'd0) begin
      head_d = mem_d[rd_ptr_d];
    end
  end

  // Flag register: clear first, then masked update on push wins bit by bit.
  always_comb begin
    flags_d = limpa_flags ? 4'b0000 : flags_q;
    if (push) begin
      flags_d = (bus.mascara_flags & bus.flags_in) | (~bus.mascara_flags & flags_d);
    end
  end

  // Branch condition from the registered flags {Z,C,S,O}.
  always_comb begin
    cond_ok = 1'b0;
    case (cond_sel)
      3'b000:  cond_ok = 1'b1;
      3'b001:  cond_ok = flags_q[3];
      3'b010:  cond_ok = ~flags_q[3];
      3'b011:  cond_ok = flags_q[1];
      3'b100:  cond_ok = ~flags_q[1];
      3'b101:  cond_ok = flags_q[2];
      3'b110:  cond_ok = flags_q[0];
      default: cond_ok = flags_q[1] ^ flags_q[0];
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      head_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      flags_q  <= 4'b0000;
    end else begin
      mem_q    <= mem_d;
      head_q   <= head_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_ula_writeback.sv
// Directed bench for ula_writeback: FIFO ordering, stalls, flags and conditions.
module tb_ula_writeback;

  logic       clk;
  logic       rst_n;
  logic       limpa_flags;
  logic [3:0] flags;
  logic [2:0] cond_sel;
  logic       cond_ok;
  int         checks;
  int         errors;

  ula_writeback_if #(.bits_palavra(16), .bits_endereco(4)) bus ();

  ula_writeback #(.bits_palavra(16), .bits_endereco(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .limpa_flags (limpa_flags),
    .flags       (flags),
    .cond_sel    (cond_sel),
    .cond_ok     (cond_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] e,
                       input logic esc, input logic [3:0] f, input logic [3:0] m);
    bus.in_valido     = v;
    bus.resultado_in  = d;
    bus.end_dest_in   = e;
    bus.escreve_in    = esc;
    bus.flags_in      = f;
    bus.mascara_flags = m;
  endtask

  // Reference encoding, flags = {Z,C,S,O}.
  function automatic logic cond_ref(input logic [3:0] f, input logic [2:0] s);
    case (s)
      3'd0:    return 1'b1;
      3'd1:    return f[3];
      3'd2:    return !f[3];
      3'd3:    return f[1];
      3'd4:    return !f[1];
      3'd5:    return f[2];
      3'd6:    return f[0];
      default: return f[1] != f[0];
    endcase
  endfunction

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    limpa_flags = 1'b0;
    cond_sel    = 3'b000;
    bus.wb_pronto = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 4'h0);

    // Reset state
    #3;
    chk("rst_wb_valido", 32'(bus.wb_valido), 32'd0);
    chk("rst_in_pronto", 32'(bus.in_pronto), 32'd1);
    chk("rst_wb_dado", 32'(bus.wb_dado), 32'h0);
    chk("rst_wb_end", 32'(bus.wb_end), 32'h0);
    chk("rst_wb_escreve", 32'(bus.wb_escreve), 32'd0);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_cond_000", 32'(cond_ok), 32'd1);
    cond_sel = 3'b010; #1;
    chk("rst_cond_010", 32'(cond_ok), 32'd1);
    cond_sel = 3'b100; #1;
    chk("rst_cond_100", 32'(cond_ok), 32'd1);
    cond_sel = 3'b001; #1;
    chk("rst_cond_001", 32'(cond_ok), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single push with one-cycle latency; cond_ok uses old flags in push cycle
    drive(1'b1, 16'h1234, 4'd3, 1'b1, 4'b0100, 4'b1111);
    bus.wb_pronto = 1'b1;
    cond_sel = 3'b101;
    #1;
    chk("push_cycle_cond_old", 32'(cond_ok), 32'd0);
    tick();
    drive(1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    chk("single_wb_valido", 32'(bus.wb_valido), 32'd1);
    chk("single_wb_dado", 32'(bus.wb_dado), 32'h1234);
    chk("single_wb_end", 32'(bus.wb_end), 32'd3);
    chk("single_wb_escreve", 32'(bus.wb_escreve), 32'd1);
    chk("single_flags", 32'(flags), 32'b0100);
    chk("single_cond_101", 32'(cond_ok), 32'd1);
    tick();
    chk("single_drained", 32'(bus.wb_valido), 32'd0);
    chk("empty_hold_dado", 32'(bus.wb_dado), 32'h1234);

    // Stall fill: A, B accepted, C refused until a pop frees a slot
    bus.wb_pronto = 1'b0;
    drive(1'b1, 16'h0001, 4'd1, 1'b1, 4'h0, 4'h0);
    tick();
    chk("fill_pronto_after_a", 32'(bus.in_pronto), 32'd1);
    drive(1'b1, 16'h0002, 4'd2, 1'b1, 4'h0, 4'h0);
    tick();
    chk("fill_pronto_after_b", 32'(bus.in_pronto), 32'd0);
    chk("fill_head_a", 32'(bus.wb_dado), 32'h0001);
    drive(1'b1, 16'h0003, 4'd5, 1'b0, 4'h0, 4'h0);
    tick();
    chk("fill_c_refused_pronto", 32'(bus.in_pronto), 32'd0);
    chk("fill_stable_dado", 32'(bus.wb_dado), 32'h0001);
    chk("fill_stable_end", 32'(bus.wb_end), 32'd1);
    bus.wb_pronto = 1'b1;
    tick();
    chk("pop_a_head_b", 32'(bus.wb_dado), 32'h0002);
    chk("pop_a_pronto", 32'(bus.in_pronto), 32'd1);
    tick();
    chk("pop_b_head_c", 32'(bus.wb_dado), 32'h0003);
    chk("pop_b_head_c_end", 32'(bus.wb_end), 32'd5);
    chk("c_escreve_zero", 32'(bus.wb_escreve), 32'd0);
    chk("c_valido", 32'(bus.wb_valido), 32'd1);
    drive(1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    tick();
    chk("fill_drained", 32'(bus.wb_valido), 32'd0);

    // Simultaneous push/pop at count 1 across pointer wrap
    bus.wb_pronto = 1'b0;
    drive(1'b1, 16'd1, 4'd1, 1'b1, 4'h0, 4'h0);
    tick();
    bus.wb_pronto = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 16'(k + 1), 4'(k + 1), 1'b1, 4'h0, 4'h0);
      #1;
      chk("stream_head", 32'(bus.wb_dado), 32'(k));
      chk("stream_valido", 32'(bus.wb_valido), 32'd1);
      chk("stream_pronto", 32'(bus.in_pronto), 32'd1);
      tick();
    end
    drive(1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    chk("stream_last_head", 32'(bus.wb_dado), 32'd9);
    tick();
    chk("stream_drained", 32'(bus.wb_valido), 32'd0);
    chk("stream_flags_kept", 32'(flags), 32'b0100);

    // Masked update and clear interaction
    drive(1'b1, 16'h0, 4'h0, 1'b0, 4'b1111, 4'b1111);
    tick();
    chk("mask_all_ones", 32'(flags), 32'b1111);
    drive(1'b1, 16'h0, 4'h0, 1'b0, 4'b0000, 4'b0101);
    tick();
    chk("mask_0101", 32'(flags), 32'b1010);
    limpa_flags = 1'b1;
    drive(1'b1, 16'h0, 4'h0, 1'b0, 4'b0001, 4'b0001);
    tick();
    chk("clear_with_push", 32'(flags), 32'b0001);
    drive(1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    tick();
    chk("clear_alone", 32'(flags), 32'b0000);
    limpa_flags = 1'b0;
    tick();

    // Condition sweep over every flag value
    for (int f = 0; f < 16; f++) begin
      drive(1'b1, 16'h0, 4'h0, 1'b0, 4'(f), 4'b1111);
      tick();
      drive(1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 4'h0);
      chk("sweep_flags", 32'(flags), 32'(f));
      for (int s = 0; s < 8; s++) begin
        cond_sel = 3'(s);
        #1;
        chk("sweep_cond", 32'(cond_ok), 32'(cond_ref(4'(f), 3'(s))));
      end
    end
    // Explicit signed less-than points
    drive(1'b1, 16'h0, 4'h0, 1'b0, 4'b0010, 4'b1111);
    cond_sel = 3'b111;
    tick();
    chk("lt_s1_o0", 32'(cond_ok), 32'd1);
    drive(1'b1, 16'h0, 4'h0, 1'b0, 4'b0011, 4'b1111);
    tick();
    chk("lt_s1_o1", 32'(cond_ok), 32'd0);
    drive(1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    tick();

    // Asynchronous reset with the FIFO full
    bus.wb_pronto = 1'b0;
    drive(1'b1, 16'hAAAA, 4'd7, 1'b1, 4'b1111, 4'b1111);
    tick();
    drive(1'b1, 16'hBBBB, 4'd8, 1'b1, 4'b1111, 4'b1111);
    tick();
    drive(1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    chk("pre_rst_full", 32'(bus.in_pronto), 32'd0);
    chk("pre_rst_flags", 32'(flags), 32'b1111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valido", 32'(bus.wb_valido), 32'd0);
    chk("async_rst_pronto", 32'(bus.in_pronto), 32'd1);
    chk("async_rst_flags", 32'(flags), 32'b0000);
    chk("async_rst_dado", 32'(bus.wb_dado), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_empty", 32'(bus.wb_valido), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
